// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its lease controller.
// Grant vectors are zero-extended to MAX_USERS bits before being passed to the helpers.
package rr_arb_pkg;

    localparam int NUM_USERS_DEF = 3;
    localparam int MAX_USERS     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEASE   = 2'd1,
        RELEASE = 2'd2
    } lease_state_t;

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [MAX_USERS-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_USERS'(1))) == '0);
    endfunction

    // Binary index of the set bit; only meaningful for a one-hot input.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_USERS-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_USERS; i++) begin
            if (vec[i]) idx = i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_lease_timer.sv
// Loadable lease down-counter: load sets the length, run decrements, expire flags the last cycle.
// Saturates at zero so a stalled lease can never wrap back to a long count.
module rr_lease_timer #(
    parameter int LEASE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [LEASE_W-1:0] load_val,
    input  logic               run,
    output logic               expire
);

    logic [LEASE_W-1:0] count;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && count != '0) begin
            count <= count - LEASE_W'(1);
        end
    end

    assign expire = (count == LEASE_W'(1));

endmodule

// File: rtl/rr_lease_ctrl.sv
// Converts a one-cycle arbiter grant into a bounded resource lease with an early-release path.
// Optional per-user acquire counters are enabled by defining RR_LEASE_STATS_EN.
module rr_lease_ctrl
    import rr_arb_pkg::*;
#(
    parameter int NUM_USERS = NUM_USERS_DEF,
    parameter int LEASE_W   = 4,
    parameter int OWNER_W   = $clog2(NUM_USERS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_USERS-1:0] user_requests,
    input  logic [NUM_USERS-1:0] granted,
    input  logic [LEASE_W-1:0]   lease_len,
    output logic                 arb_hold,
    output logic                 res_valid,
    output logic [NUM_USERS-1:0] res_sel,
    output logic [OWNER_W-1:0]   res_owner,
    output logic                 lease_done,
    output logic                 grant_err
`ifdef RR_LEASE_STATS_EN
    ,
    output logic [NUM_USERS*8-1:0] lease_count
`endif
);

    lease_state_t           state;
    logic [MAX_USERS-1:0]   grant_ext;
    logic                   grant_onehot;
    logic                   acquire;
    logic                   multi_hot;
    logic                   owner_req;
    logic                   expire;
    logic [OWNER_W-1:0]     grant_idx;
    logic [LEASE_W-1:0]     load_val;

    assign grant_ext    = MAX_USERS'(granted);
    assign grant_onehot = is_onehot(grant_ext);
    assign grant_idx    = OWNER_W'(onehot_to_idx(grant_ext));
    assign acquire      = (state == IDLE) && grant_onehot && ((granted & user_requests) != '0);
    assign multi_hot    = (granted != '0) && !grant_onehot;
    // res_sel holds the owner's one-hot select for the whole LEASE state.
    assign owner_req    = (user_requests & res_sel) != '0;
    assign load_val     = (lease_len == '0) ? LEASE_W'(1) : lease_len;

    rr_lease_timer #(
        .LEASE_W (LEASE_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (acquire),
        .load_val (load_val),
        .run      (state == LEASE),
        .expire   (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            arb_hold   <= 1'b0;
            res_valid  <= 1'b0;
            res_sel    <= '0;
            res_owner  <= '0;
            lease_done <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            lease_done <= 1'b0;
            grant_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (acquire) begin
                        state     <= LEASE;
                        arb_hold  <= 1'b1;
                        res_valid <= 1'b1;
                        res_sel   <= granted;
                        res_owner <= grant_idx;
                    end else if (multi_hot) begin
                        grant_err <= 1'b1;
                    end
                end
                LEASE: begin
                    if (expire || !owner_req) begin
                        state      <= RELEASE;
                        res_valid  <= 1'b0;
                        res_sel    <= '0;
                        res_owner  <= '0;
                        lease_done <= 1'b1;
                    end
                end
                RELEASE: begin
                    state    <= IDLE;
                    arb_hold <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    arb_hold  <= 1'b0;
                    res_valid <= 1'b0;
                    res_sel   <= '0;
                    res_owner <= '0;
                end
            endcase
        end
    end

`ifdef RR_LEASE_STATS_EN
    logic [7:0] acq_cnt [NUM_USERS];

    for (genvar u = 0; u < NUM_USERS; u++) begin : g_stats
        always_ff @(posedge clock) begin
            if (reset) begin
                acq_cnt[u] <= '0;
            end else if (acquire && granted[u] && acq_cnt[u] != 8'hFF) begin
                acq_cnt[u] <= acq_cnt[u] + 8'd1;
            end
        end
        assign lease_count[u*8 +: 8] = acq_cnt[u];
    end
`endif

endmodule

// File: tb/tb_rr_lease_ctrl.sv
// Scoreboard bench for rr_lease_ctrl: directed per-cycle vectors queue expected outputs,
// and a monitor compares the registered outputs just after each rising edge.
module tb_rr_lease_ctrl;

    logic       clock;
    logic       reset;
    logic [2:0] user_requests;
    logic [2:0] granted;
    logic [3:0] lease_len;
    logic       arb_hold;
    logic       res_valid;
    logic [2:0] res_sel;
    logic [1:0] res_owner;
    logic       lease_done;
    logic       grant_err;
`ifdef RR_LEASE_STATS_EN
    logic [23:0] lease_count;
`endif

    int checks = 0;
    int errors = 0;

    // Packed order: res_valid, res_sel, res_owner, arb_hold, lease_done, grant_err.
    typedef struct {
        string      nm;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];

    rr_lease_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .user_requests (user_requests),
        .granted       (granted),
        .lease_len     (lease_len),
        .arb_hold      (arb_hold),
        .res_valid     (res_valid),
        .res_sel       (res_sel),
        .res_owner     (res_owner),
        .lease_done    (lease_done),
        .grant_err     (grant_err)
`ifdef RR_LEASE_STATS_EN
        ,
        .lease_count   (lease_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, actual, expected);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare the full output vector.
    always @(posedge clock) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.nm, 32'({res_valid, res_sel, res_owner, arb_hold, lease_done, grant_err}),
                  32'(e.exp));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic rst, input logic [2:0] req, input logic [2:0] gnt,
                       input logic [3:0] len, input logic rv, input logic [2:0] sel,
                       input logic [1:0] own, input logic hold, input logic done,
                       input logic err, input string nm);
        exp_t e;
        @(negedge clock);
        reset         = rst;
        user_requests = req;
        granted       = gnt;
        lease_len     = len;
        e.nm  = nm;
        e.exp = {rv, sel, own, hold, done, err};
        sb.push_back(e);
    endtask

    initial begin
        reset         = 1'b1;
        user_requests = '0;
        granted       = '0;
        lease_len     = '0;

        //   rst req     gnt     len    rv sel     own   hold done err
        cyc(1, 3'b000, 3'b000, 4'd0,  0, 3'b000, 2'd0, 0, 0, 0, "reset_a");
        cyc(1, 3'b111, 3'b001, 4'd3,  0, 3'b000, 2'd0, 0, 0, 0, "reset_b");

        // Basic lease, length 3.
        cyc(0, 3'b001, 3'b001, 4'd3,  1, 3'b001, 2'd0, 1, 0, 0, "basic_acq");
        cyc(0, 3'b001, 3'b000, 4'd3,  1, 3'b001, 2'd0, 1, 0, 0, "basic_c2");
        cyc(0, 3'b001, 3'b000, 4'd3,  1, 3'b001, 2'd0, 1, 0, 0, "basic_c3");
        cyc(0, 3'b001, 3'b000, 4'd3,  0, 3'b000, 2'd0, 1, 1, 0, "basic_done");
        cyc(0, 3'b001, 3'b000, 4'd3,  0, 3'b000, 2'd0, 0, 0, 0, "basic_idle");

        // Early release after two lease cycles of an 8-cycle lease.
        cyc(0, 3'b010, 3'b010, 4'd8,  1, 3'b010, 2'd1, 1, 0, 0, "early_acq");
        cyc(0, 3'b010, 3'b000, 4'd8,  1, 3'b010, 2'd1, 1, 0, 0, "early_c2");
        cyc(0, 3'b000, 3'b000, 4'd8,  0, 3'b000, 2'd0, 1, 1, 0, "early_done");
        cyc(0, 3'b000, 3'b000, 4'd8,  0, 3'b000, 2'd0, 0, 0, 0, "early_idle");

        // Zero length behaves as a one-cycle lease.
        cyc(0, 3'b100, 3'b100, 4'd0,  1, 3'b100, 2'd2, 1, 0, 0, "zero_acq");
        cyc(0, 3'b100, 3'b000, 4'd0,  0, 3'b000, 2'd0, 1, 1, 0, "zero_done");
        cyc(0, 3'b100, 3'b000, 4'd0,  0, 3'b000, 2'd0, 0, 0, 0, "zero_idle");

        // Multi-hot grant pulses grant_err once; stale one-hot grant is ignored.
        cyc(0, 3'b011, 3'b011, 4'd2,  0, 3'b000, 2'd0, 0, 0, 1, "multi_err");
        cyc(0, 3'b000, 3'b000, 4'd2,  0, 3'b000, 2'd0, 0, 0, 0, "multi_clear");
        cyc(0, 3'b000, 3'b001, 4'd2,  0, 3'b000, 2'd0, 0, 0, 0, "stale_grant");

        // Grants during LEASE/RELEASE are ignored; mid-lease lease_len change has no effect.
        cyc(0, 3'b001, 3'b001, 4'd2,  1, 3'b001, 2'd0, 1, 0, 0, "busy_acq");
        cyc(0, 3'b011, 3'b010, 4'd15, 1, 3'b001, 2'd0, 1, 0, 0, "busy_grant");
        cyc(0, 3'b011, 3'b010, 4'd2,  0, 3'b000, 2'd0, 1, 1, 0, "busy_done");
        cyc(0, 3'b011, 3'b010, 4'd2,  0, 3'b000, 2'd0, 0, 0, 0, "busy_rel_gnt");
        cyc(0, 3'b011, 3'b010, 4'd2,  1, 3'b010, 2'd1, 1, 0, 0, "next_acq");
        cyc(0, 3'b010, 3'b000, 4'd2,  1, 3'b010, 2'd1, 1, 0, 0, "next_c2");
        cyc(0, 3'b010, 3'b000, 4'd2,  0, 3'b000, 2'd0, 1, 1, 0, "next_done");
        cyc(0, 3'b000, 3'b000, 4'd2,  0, 3'b000, 2'd0, 0, 0, 0, "next_idle");

        // Reset during the second lease cycle: outputs clear, no lease_done follows.
        cyc(0, 3'b001, 3'b001, 4'd5,  1, 3'b001, 2'd0, 1, 0, 0, "rst_acq");
`ifdef RR_LEASE_STATS_EN
        @(posedge clock);
        #2;
        check("stats_before_reset", 32'(lease_count), 32'({8'd1, 8'd2, 8'd3}));
`endif
        cyc(0, 3'b001, 3'b000, 4'd5,  1, 3'b001, 2'd0, 1, 0, 0, "rst_c2");
        cyc(1, 3'b001, 3'b000, 4'd5,  0, 3'b000, 2'd0, 0, 0, 0, "rst_mid");
        cyc(0, 3'b001, 3'b000, 4'd5,  0, 3'b000, 2'd0, 0, 0, 0, "rst_after");
        cyc(0, 3'b000, 3'b000, 4'd5,  0, 3'b000, 2'd0, 0, 0, 0, "rst_quiet");

        // Drain the scoreboard within a bounded number of cycles.
        begin
            int budget;
            budget = 0;
            while (sb.size() != 0 && budget < 10) begin
                @(posedge clock);
                budget++;
            end
            #2;
            check("scoreboard_drained", 32'(sb.size()), 32'd0);
        end
`ifdef RR_LEASE_STATS_EN
        check("stats_after_reset", 32'(lease_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
